// File: rtl/seg_scan_if.sv
// Signal bundle between the upstream nibble mux / control logic and the scan controller.
// There is no handshake: sel is registered, digit_val must be a combinational function of sel.
interface seg_scan_if;
  logic       en;
  logic [3:0] digit_val;
  logic [3:0] blank_mask;
  logic [3:0] dp_mask;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output en, digit_val, blank_mask, dp_mask,
    input  sel, an, seg, dp
  );

  modport slave (
    input  en, digit_val, blank_mask, dp_mask,
    output sel, an, seg, dp
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with a blanking gap
// at the start of every digit slot; all display outputs are registered.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus,
  output logic [1:0]  o_dbg_phase
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    PH_DARK  = 2'd0,
    PH_BLANK = 2'd1,
    PH_DRIVE = 2'd2
  } phase_t;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic          r_restart;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic [CW-1:0] w_cnt_eff;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_sel_nxt;
  logic          w_restart_nxt;
  logic          w_lit;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;
  phase_t        w_phase;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // cnt holds while disabled; r_restart makes the first enabled edge behave as cnt=0.
  always_comb begin
    w_cnt_eff     = r_restart ? '0 : r_cnt;
    w_cnt_nxt     = r_cnt;
    w_sel_nxt     = r_sel;
    w_restart_nxt = r_restart;
    w_phase       = PH_DARK;

    if (bus.en) begin
      w_restart_nxt = 1'b0;
      w_phase       = (w_cnt_eff < BLANK_CNT) ? PH_BLANK : PH_DRIVE;
      if (w_cnt_eff == LAST_CNT) begin
        w_cnt_nxt = '0;
        w_sel_nxt = r_sel + 2'd1;
      end else begin
        w_cnt_nxt = w_cnt_eff + 1'b1;
      end
    end else begin
      w_restart_nxt = 1'b1;
    end

    w_lit     = (w_phase == PH_DRIVE) && !bus.blank_mask[r_sel];
    w_an_nxt  = 4'b1111;
    w_seg_nxt = 7'b1111111;
    w_dp_nxt  = 1'b1;
    if (w_lit) begin
      w_an_nxt  = ~(4'b0001 << r_sel);
      w_seg_nxt = hex_decode(bus.digit_val);
      w_dp_nxt  = ~bus.dp_mask[r_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sel     <= 2'b00;
      r_restart <= 1'b0;
      r_an      <= 4'b1111;
      r_seg     <= 7'b1111111;
      r_dp      <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_restart <= w_restart_nxt;
      r_an      <= w_an_nxt;
      r_seg     <= w_seg_nxt;
      r_dp      <= w_dp_nxt;
    end
  end

  assign bus.sel     = r_sel;
  assign bus.an      = r_an;
  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign o_dbg_phase = w_phase;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl: a slot-age model predicts every
// registered output edge, a monitor compares one time unit after each rising edge.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] bm;
  logic [3:0] dpm;
  logic [3:0] nib [4];
  logic       dv_force;
  logic [3:0] dv_val;
  logic [1:0] dbg_phase;

  int checks   = 0;
  int failures = 0;

  logic [13:0] exp_q [$];

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // reference state: current digit and how many enabled cycles it has spent in its slot
  int m_sel = 0;
  int m_age = 0;
  logic m_drive;

  seg_scan_if bus ();

  assign bus.en         = en;
  assign bus.blank_mask = bm;
  assign bus.dp_mask    = dpm;
  assign bus.digit_val  = dv_force ? dv_val : nib[bus.sel];

  seg_scan_ctrl #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_phase (dbg_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // predict the outputs of the coming rising edge, then advance to the next falling edge
  task automatic cycle();
    logic [3:0] dv;
    logic       lit;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    dv      = dv_force ? dv_val : nib[m_sel];
    lit     = 1'b0;
    m_drive = 1'b0;
    an_e    = 4'b1111;
    seg_e   = 7'b1111111;
    dp_e    = 1'b1;
    if (rst) begin
      m_sel = 0;
      m_age = 0;
    end else if (!en) begin
      m_age = 0;
    end else begin
      m_drive = (m_age >= BLANK);
      lit     = m_drive && !bm[m_sel];
      if (lit) begin
        an_e  = 4'b1111 ^ (4'b0001 << m_sel);
        seg_e = hex_tbl[dv];
        dp_e  = ~dpm[m_sel];
      end
      m_age = m_age + 1;
      if (m_age == DIV) begin
        m_age = 0;
        m_sel = (m_sel + 1) % 4;
      end
    end
    exp_q.push_back({2'(m_sel), an_e, seg_e, dp_e});
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_slot(input int sel, input int age, input string name);
    int k;
    k = 0;
    while (!(m_sel == sel && m_age == age) && k < 64) begin
      cycle();
      k++;
    end
    checks++;
    if (!(m_sel == sel && m_age == age)) begin
      failures++;
      $display("FAIL %s: reached sel=%0d age=%0d, required sel=%0d age=%0d", name, m_sel, m_age, sel, age);
    end
  endtask

  always @(posedge clk) begin
    logic [13:0] e;
    logic [13:0] got;
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = {bus.sel, bus.an, bus.seg, bus.dp};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL scan_out t=%0t got sel=%b an=%b seg=%b dp=%b, expected sel=%b an=%b seg=%b dp=%b",
                 $time, got[13:12], got[11:8], got[7:1], got[0], e[13:12], e[11:8], e[7:1], e[0]);
      end
    end
  end

  initial begin
    int sweep;
    rst      = 1'b1;
    en       = 1'b1;
    bm       = 4'b0000;
    dpm      = 4'b0000;
    dv_force = 1'b0;
    dv_val   = 4'h0;
    for (int i = 0; i < 4; i++) nib[i] = 4'(i);

    // reset held for two edges, then plain scan of digits showing their own index
    run(2);
    rst = 1'b0;
    run(40);

    // decode sweep: advance the forced nibble only on drive-phase edges
    dv_force = 1'b1;
    sweep    = 0;
    for (int i = 0; i < 64; i++) begin
      dv_val = 4'(sweep);
      cycle();
      if (m_drive) sweep = sweep + 1;
    end
    dv_force = 1'b0;

    // leading-digit blanking and a decimal point on digit 1
    bm  = 4'b1000;
    dpm = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 4; j++) nib[j] = 4'($urandom_range(0, 15));
      cycle();
    end
    bm  = 4'b0000;
    dpm = 4'b0000;

    // enable drop mid-drive on digit 2, then resume
    wait_slot(2, 5, "en_drop_slot");
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(12);

    // reset pulse late in digit 3's slot
    wait_slot(3, 6, "rst_pulse_slot");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(20);

    // randomized mix of enable gaps, rare resets, mask and data changes
    for (int i = 0; i < 500; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bm  = 4'($urandom_range(0, 15));
        dpm = 4'($urandom_range(0, 15));
      end
      for (int j = 0; j < 4; j++) nib[j] = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0;
    en  = 1'b1;

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
